pl_clk_rst_monitor: RTL

Synthesizable, parametrised monitor for PL clocks and reset in the extensible platform. Runs on CIPS pl_clk0 and oversamples NUM_CH monitored clock signals, such as clk_wizard outputs or derived clocks. Counts rising edges per channel over a fixed reference window and checks each count against runtime min/max limits. Measures pl_resetn release latency, flags release timeout, and flags re-assertion after release. Gives the platform a hardware replacement for bench-side clock and reset polling, readable by PS or ILA.

---
 rtl/pl_clk_rst_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pl_clk_rst_monitor.sv
// Frequency/presence monitor for NUM_CH asynchronous PL clocks plus pl_resetn
// release-latency, timeout and re-assertion tracking, all on pl_clk0.
module pl_clk_rst_monitor #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1000,
  parameter int RST_W       = 16,
  parameter int RST_TIMEOUT = 256
) (
  input  logic                    pl_clk0,
  input  logic                    pl_reset,
  input  logic [NUM_CH-1:0]       mon_clk,
  input  logic                    mon_resetn,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CH*CNT_W-1:0] lim_min,
  input  logic [NUM_CH*CNT_W-1:0] lim_max,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt,
  output logic                    cnt_valid,
  output logic [NUM_CH-1:0]       alive,
  output logic [NUM_CH-1:0]       fail,
  output logic                    rst_released,
  output logic [RST_W-1:0]        rst_release_cyc,
  output logic                    rst_timeout,
  output logic                    rst_reassert
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [RST_W-1:0] RST_MAX   = {RST_W{1'b1}};
  localparam logic [RST_W-1:0] RST_LIMIT = RST_W'(RST_TIMEOUT);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  logic [NUM_CH-1:0]       clk_s1_reg, clk_s2_reg, clk_s3_reg;
  logic                    rstn_s1_reg, rstn_s2_reg, rstn_s3_reg;
  logic [NUM_CH-1:0]       edge_det;

  state_t                  state_reg, state_next;
  logic [WIN_W-1:0]        win_reg, win_next;
  logic                    terminal, acc_keep;

  logic [NUM_CH*CNT_W-1:0] acc_reg, acc_next;
  logic [NUM_CH*CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic                    cnt_valid_reg;
  logic [NUM_CH-1:0]       alive_reg, alive_next;
  logic [NUM_CH-1:0]       fail_reg, fail_next;
  logic [NUM_CH-1:0]       out_of_range;

  logic [RST_W-1:0]        rst_cnt_reg, rst_cnt_next;
  logic                    released_reg, release_now;
  logic [RST_W-1:0]        release_cyc_reg, release_cyc_next;
  logic                    timeout_reg, timeout_next, timeout_set;
  logic                    reassert_reg, reassert_next, reassert_set;

  assign edge_det = clk_s2_reg & ~clk_s3_reg;

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    terminal   = 1'b0;
    acc_keep   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        win_next = '0;
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          state_next = ST_IDLE;
          win_next   = '0;
        end else if (win_reg == WIN_LAST) begin
          terminal = 1'b1;
          win_next = '0;
        end else begin
          win_next = win_reg + 1'b1;
          acc_keep = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // acc_sum folds in this cycle's edge so the terminal-cycle edge closes the window
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] acc_cur, acc_sum;
      assign acc_cur = acc_reg[gi*CNT_W +: CNT_W];
      assign acc_sum = (edge_det[gi] && acc_cur != CNT_MAX) ? acc_cur + 1'b1 : acc_cur;
      assign acc_next[gi*CNT_W +: CNT_W] = acc_keep ? acc_sum : '0;
      assign edge_cnt_next[gi*CNT_W +: CNT_W] =
        terminal ? acc_sum : edge_cnt_reg[gi*CNT_W +: CNT_W];
      assign out_of_range[gi] = (acc_sum < lim_min[gi*CNT_W +: CNT_W]) ||
                                (acc_sum > lim_max[gi*CNT_W +: CNT_W]);
      assign fail_next[gi]  = (fail_reg[gi] & ~clear) | (terminal & out_of_range[gi]);
      assign alive_next[gi] = terminal ? (acc_sum != '0) : alive_reg[gi];
    end
  endgenerate

  assign release_now      = !released_reg && rstn_s3_reg;
  assign rst_cnt_next     = (!released_reg && !rstn_s3_reg && rst_cnt_reg != RST_MAX) ?
                            rst_cnt_reg + 1'b1 : rst_cnt_reg;
  assign release_cyc_next = release_now ? rst_cnt_reg : release_cyc_reg;
  assign timeout_set      = !released_reg && (rst_cnt_reg >= RST_LIMIT);
  assign reassert_set     = released_reg && !rstn_s3_reg;
  assign timeout_next     = (timeout_reg & ~clear) | timeout_set;
  assign reassert_next    = (reassert_reg & ~clear) | reassert_set;

  always_ff @(posedge pl_clk0) begin
    if (pl_reset) begin
      clk_s1_reg      <= '0;
      clk_s2_reg      <= '0;
      clk_s3_reg      <= '0;
      rstn_s1_reg     <= 1'b0;
      rstn_s2_reg     <= 1'b0;
      rstn_s3_reg     <= 1'b0;
      state_reg       <= ST_IDLE;
      win_reg         <= '0;
      acc_reg         <= '0;
      edge_cnt_reg    <= '0;
      cnt_valid_reg   <= 1'b0;
      alive_reg       <= '0;
      fail_reg        <= '0;
      rst_cnt_reg     <= '0;
      released_reg    <= 1'b0;
      release_cyc_reg <= '0;
      timeout_reg     <= 1'b0;
      reassert_reg    <= 1'b0;
    end else begin
      clk_s1_reg      <= mon_clk;
      clk_s2_reg      <= clk_s1_reg;
      clk_s3_reg      <= clk_s2_reg;
      rstn_s1_reg     <= mon_resetn;
      rstn_s2_reg     <= rstn_s1_reg;
      rstn_s3_reg     <= rstn_s2_reg;
      state_reg       <= state_next;
      win_reg         <= win_next;
      acc_reg         <= acc_next;
      edge_cnt_reg    <= edge_cnt_next;
      cnt_valid_reg   <= terminal;
      alive_reg       <= alive_next;
      fail_reg        <= fail_next;
      rst_cnt_reg     <= rst_cnt_next;
      released_reg    <= released_reg | release_now;
      release_cyc_reg <= release_cyc_next;
      timeout_reg     <= timeout_next;
      reassert_reg    <= reassert_next;
    end
  end

  assign edge_cnt        = edge_cnt_reg;
  assign cnt_valid       = cnt_valid_reg;
  assign alive           = alive_reg;
  assign fail            = fail_reg;
  assign rst_released    = released_reg;
  assign rst_release_cyc = release_cyc_reg;
  assign rst_timeout     = timeout_reg;
  assign rst_reassert    = reassert_reg;

endmodule
